quad_seq_ctrl: RTL and testbench

//  Sequencer for the 4-phase commutating clock of the quadrature sampling mixer.

---
 rtl/quad_pkg.sv | 21 ++
 rtl/quad_cfg_shadow.sv | 69 ++++++
 rtl/quad_seq_ctrl.sv | 111 +++++++++++
 tb/tb_quad_seq_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature mixer phase sequencer.
package quad_pkg;

  localparam int DIV_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Reverse rotation walks 0,3,2,1 so position 0 always maps to phase 0.
  function automatic logic [1:0] phase_of(input logic [1:0] pos, input logic rev);
    return rev ? 2'(2'd0 - pos) : pos;
  endfunction

endpackage

// File: rtl/quad_cfg_shadow.sv
// Configuration shadow register: valid/ready load, clamping, and transfer to the
// active configuration whenever the sequencer reports a safe point.
module quad_cfg_shadow
  import quad_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_gap,
  input  logic             cfg_rev,
  input  logic             apply_ok,
  output logic             cfg_ready,
  output logic [DIV_W-1:0] act_div,
  output logic [DIV_W-1:0] act_gap,
  output logic             act_rev
);

  localparam int               RST_DIV_I = (DEF_DIV < 1) ? 1 : DEF_DIV;
  localparam logic [DIV_W-1:0] RST_DIV   = RST_DIV_I[DIV_W-1:0];

  logic             full;
  logic [DIV_W-1:0] shd_div;
  logic [DIV_W-1:0] shd_gap;
  logic             shd_rev;
  logic [DIV_W-1:0] in_div;
  logic [DIV_W-1:0] in_gap;
  logic             load;
  logic             apply;

  // Clamp on entry so the active config always satisfies d>=1 and g<=d-1.
  always_comb begin
    in_div = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
    in_gap = (cfg_gap > in_div - DIV_W'(1)) ? in_div - DIV_W'(1) : cfg_gap;
  end

  // Load needs an empty shadow and apply needs a full one, so they never coincide.
  assign load      = cfg_valid && !full;
  assign apply     = full && apply_ok;
  assign cfg_ready = !full;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 1'b0;
      shd_div <= RST_DIV;
      shd_gap <= '0;
      shd_rev <= 1'b0;
      act_div <= RST_DIV;
      act_gap <= '0;
      act_rev <= 1'b0;
    end else if (apply) begin
      full    <= 1'b0;
      act_div <= shd_div;
      act_gap <= shd_gap;
      act_rev <= shd_rev;
    end else if (load) begin
      full    <= 1'b1;
      shd_div <= in_div;
      shd_gap <= in_gap;
      shd_rev <= cfg_rev;
    end
  end

endmodule

// File: rtl/quad_seq_ctrl.sv
// 4-phase commutating clock sequencer: one-hot phases with programmable length,
// dead time and rotation, starting and stopping only on whole-cycle boundaries.
module quad_seq_ctrl
  import quad_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_gap,
  input  logic             cfg_rev,
  output logic [3:0]       quad_out,
  output logic [1:0]       phase,
  output logic             sync,
  output logic             running
);

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [1:0]       pos;
  logic [DIV_W-1:0] act_div;
  logic [DIV_W-1:0] act_gap;
  logic             act_rev;
  logic             cnt_last;
  logic             boundary;
  logic [DIV_W-1:0] adv_cnt;
  logic [1:0]       adv_pos;
  logic [1:0]       adv_phase;
  logic [3:0]       adv_quad;
  logic             adv_sync;

  quad_cfg_shadow #(
    .DIV_W  (DIV_W),
    .DEF_DIV(DEF_DIV)
  ) u_cfg (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_gap  (cfg_gap),
    .cfg_rev  (cfg_rev),
    .apply_ok (state == IDLE || boundary),
    .cfg_ready(cfg_ready),
    .act_div  (act_div),
    .act_gap  (act_gap),
    .act_rev  (act_rev)
  );

  // Next counter position while commutating; outputs are registered from these
  // so they describe the cycle that begins at the edge.
  // NOTE: every always_comb output is assigned on every path, so no latches form.
  always_comb begin
    cnt_last  = (cnt == act_div - DIV_W'(1));
    boundary  = cnt_last && (pos == 2'd3);
    adv_cnt   = cnt_last ? '0 : cnt + DIV_W'(1);
    adv_pos   = cnt_last ? pos + 2'd1 : pos;
    adv_phase = phase_of(adv_pos, act_rev);
    adv_quad  = (adv_cnt < act_div - act_gap) ? onehot4(adv_phase) : 4'b0000;
    adv_sync  = (adv_pos == 2'd0) && (adv_cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pos      <= '0;
      quad_out <= '0;
      phase    <= '0;
      sync     <= 1'b0;
      running  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state    <= RUN;
            quad_out <= onehot4(2'd0);
            sync     <= 1'b1;
            running  <= 1'b1;
          end
        end
        RUN, STOP: begin
          if (state == STOP && !en && boundary) begin
            state    <= IDLE;
            cnt      <= '0;
            pos      <= '0;
            quad_out <= '0;
            phase    <= '0;
            sync     <= 1'b0;
            running  <= 1'b0;
          end else begin
            // A re-raised en simply resumes RUN; commutation never pauses.
            state    <= en ? RUN : STOP;
            cnt      <= adv_cnt;
            pos      <= adv_pos;
            quad_out <= adv_quad;
            phase    <= adv_phase;
            sync     <= adv_sync;
            running  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_seq_ctrl.sv
// Bench for quad_seq_ctrl: directed scenarios plus random traffic, checked against
// a model that tracks elapsed time within the commutation cycle.
module tb_quad_seq_ctrl;

  localparam int DIV_W = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_gap;
  logic             cfg_rev;
  logic [3:0]       quad_out;
  logic [1:0]       phase;
  logic             sync;
  logic             running;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_step = 0;

  // Reference model: t counts clk cycles since the start of the current cycle.
  bit m_run, m_stop, m_full, m_rev, s_rev;
  int m_t, m_d, m_g, s_d, s_g;

  quad_seq_ctrl #(
    .DIV_W  (DIV_W),
    .DEF_DIV(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_gap  (cfg_gap),
    .cfg_rev  (cfg_rev),
    .quad_out (quad_out),
    .phase    (phase),
    .sync     (sync),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, n_step, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_stop = 0;
    m_full = 0;
    m_t    = 0;
    m_d    = 1;
    m_g    = 0;
    m_rev  = 0;
  endtask

  task automatic check_outputs();
    int p, c, ph;
    int eq, ep, es;
    if (m_run) begin
      p  = m_t / m_d;
      c  = m_t % m_d;
      ph = m_rev ? (4 - p) % 4 : p;
      eq = (c < m_d - m_g) ? (1 << ph) : 0;
      ep = ph;
      es = (m_t == 0) ? 1 : 0;
    end else begin
      eq = 0;
      ep = 0;
      es = 0;
    end
    check("quad_out", quad_out, eq);
    check("phase", phase, ep);
    check("sync", sync, es);
    check("running", running, m_run);
    check("cfg_ready", cfg_ready, !m_full);
  endtask

  // One clock edge: advance the model with the inputs sampled there, then compare.
  task automatic step();
    bit bnd, ld, ap;
    @(posedge clk);
    n_step++;
    bnd = m_run && (m_t == 4 * m_d - 1);
    ld  = cfg_valid && !m_full;
    ap  = m_full && (!m_run || bnd);
    if (!m_run) begin
      if (en) begin
        m_run  = 1;
        m_stop = 0;
        m_t    = 0;
      end
    end else if (!en && m_stop && bnd) begin
      m_run = 0;
      m_t   = 0;
    end else begin
      m_stop = !en;
      m_t    = bnd ? 0 : m_t + 1;
    end
    if (ap) begin
      m_d    = s_d;
      m_g    = s_g;
      m_rev  = s_rev;
      m_full = 0;
    end
    if (ld) begin
      s_d    = (cfg_div == 0) ? 1 : int'(cfg_div);
      s_g    = (int'(cfg_gap) > s_d - 1) ? s_d - 1 : int'(cfg_gap);
      s_rev  = cfg_rev;
      m_full = 1;
    end
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic offer_cfg(input int d, input int g, input bit r);
    cfg_valid = 1'b1;
    cfg_div   = DIV_W'(d);
    cfg_gap   = DIV_W'(g);
    cfg_rev   = r;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_gap   = '0;
    cfg_rev   = 1'b0;
    model_reset();
    #12;
    check_outputs();
    rst = 1'b0;
    run(2);

    // Plain divide-by-4 quadrature; first 0001 one edge after en.
    en = 1'b1;
    step();
    check("first_phase0", quad_out, 4'b0001);
    run(12);

    // div=3 gap=1, then an oversized gap that must clamp to d-1.
    offer_cfg(3, 1, 0);
    run(30);
    offer_cfg(3, 5, 0);
    run(30);

    // Reverse rotation.
    offer_cfg(1, 0, 1);
    run(16);

    // Stop mid-phase at position 1, then a short en drop that must not interrupt.
    offer_cfg(3, 0, 0);
    for (int i = 0; i < 60 && !(m_run && m_d == 3 && m_t == 4); i++) step();
    check("reached_pos1", m_t, 4);
    en = 1'b0;
    run(14);
    check("stopped", running, 1'b0);
    en = 1'b1;
    run(7);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(20);

    // Mid-cycle reconfiguration with a second offer while the shadow is busy.
    run(2);
    cfg_valid = 1'b1;
    cfg_div   = 8'd2;
    cfg_gap   = 8'd0;
    cfg_rev   = 1'b0;
    step();
    cfg_div = 8'd4;
    cfg_gap = 8'd1;
    step();
    cfg_valid = 1'b0;
    run(24);

    // Random traffic over small div/gap values and en toggling.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_div   = DIV_W'($urandom_range(0, 4));
      cfg_gap   = DIV_W'($urandom_range(0, 5));
      cfg_rev   = 1'($urandom_range(0, 1));
      step();
    end
    cfg_valid = 1'b0;

    // Asynchronous reset mid-phase with the shadow loaded.
    en = 1'b1;
    offer_cfg(3, 1, 1);
    run(2);
    #2;
    rst = 1'b1;
    #1;
    check("async_quad", quad_out, 4'b0000);
    check("async_running", running, 1'b0);
    check("async_ready", cfg_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    en = 1'b0;
    step();
    en = 1'b1;
    run(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
